// File: rtl/painterengine_gpu_video_scheduler_pkg.sv
// Shared scheduler definitions: FSM encoding and 640x480@60 timing.
// Reused by the scheduler, the line fetch unit and the bench.
package painterengine_gpu_video_scheduler_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_CW       = 12;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/painterengine_gpu_timing_counter.sv
// One timing axis: count with wrap, plus region decode of the
// value the counter holds after this edge.
module painterengine_gpu_timing_counter
    import painterengine_gpu_video_scheduler_pkg::*;
#(
    parameter int ACTIVE = VGA_H_ACTIVE,
    parameter int FP     = VGA_H_FP,
    parameter int SYNC   = VGA_H_SYNC,
    parameter int BP     = VGA_H_BP,
    parameter int CW     = VGA_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic          active_next,
    output logic          sync_next
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACT_END  = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_BEG = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] SYNC_END = CW'(ACTIVE + FP + SYNC);

    logic [CW-1:0] cnt_next;

    assign wrap        = step && (cnt == LAST);
    assign cnt_next    = !step ? cnt : (wrap ? '0 : cnt + 1'b1);
    assign active_next = cnt_next < ACT_END;
    assign sync_next   = (cnt_next >= SYNC_BEG) && (cnt_next < SYNC_END);

    // Counter register; holds between pixel pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt_next;
    end

endmodule

// File: rtl/painterengine_gpu_video_scheduler.sv
// Video timing scheduler: H/V counters, sync/DE decode and
// ahead-of-time line fetch requests, started/stopped on frame edges.
module painterengine_gpu_video_scheduler
    import painterengine_gpu_video_scheduler_pkg::*;
#(
    parameter int H_ACTIVE  = VGA_H_ACTIVE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_ACTIVE  = VGA_V_ACTIVE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CW        = VGA_CW
) (
    input  logic          i_wire_5x_pixel_clock,
    input  logic          i_wire_resetn,
    input  logic          i_wire_pixel_clock,
    input  logic          i_wire_enable,
    input  logic          i_wire_line_ack,
    input  logic          i_wire_clear,
    output logic          o_wire_hsync,
    output logic          o_wire_vsync,
    output logic          o_wire_de,
    output logic [CW-1:0] o_wire_x,
    output logic [CW-1:0] o_wire_y,
    output logic          o_wire_frame_start,
    output logic          o_wire_line_req,
    output logic [CW-1:0] o_wire_line_num,
    output logic          o_wire_underflow,
    output logic          o_wire_busy
);

    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [CW-1:0] H_PRE  = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);

    logic [1:0]    state, state_next;
    logic          busy, run, start, h_step;
    logic [CW-1:0] h, v, next_line, line_num;
    logic          h_wrap, h_act, h_sync;
    logic          v_wrap, v_act, v_sync;
    logic          on_next, de_next, req_hit, new_req, uf_set;
    logic          de, hsync, vsync, frame_start, req, underflow;

    assign busy   = state != ST_IDLE;
    assign run    = busy && i_wire_enable;
    assign start  = !busy && i_wire_enable && i_wire_pixel_clock;
    assign h_step = busy && i_wire_pixel_clock;

    painterengine_gpu_timing_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
    ) u_h (
        .clk        (i_wire_5x_pixel_clock),
        .rst_n      (i_wire_resetn),
        .step       (h_step),
        .cnt        (h),
        .wrap       (h_wrap),
        .active_next(h_act),
        .sync_next  (h_sync)
    );

    painterengine_gpu_timing_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
    ) u_v (
        .clk        (i_wire_5x_pixel_clock),
        .rst_n      (i_wire_resetn),
        .step       (h_wrap),
        .cnt        (v),
        .wrap       (v_wrap),
        .active_next(v_act),
        .sync_next  (v_sync)
    );

    // Enable acts at once between RUN and DRAIN, but idling waits for the v wrap.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (start) state_next = ST_RUN;
            end
            ST_RUN, ST_DRAIN: begin
                if (v_wrap && !i_wire_enable) state_next = ST_IDLE;
                else if (i_wire_enable)       state_next = ST_RUN;
                else                          state_next = ST_DRAIN;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign on_next   = state_next != ST_IDLE;
    assign de_next   = on_next && h_act && v_act;
    assign next_line = (v == V_LAST) ? '0 : v + 1'b1;
    assign req_hit   = run && h_step && (h == H_PRE) && (next_line < V_ACT);
    assign new_req   = start || req_hit;
    assign uf_set    = req && ((de_next && !de) || new_req);

    // FSM state register.
    always_ff @(posedge i_wire_5x_pixel_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) state <= ST_IDLE;
        else                state <= state_next;
    end

    // Video outputs decoded from next-edge counters so they line up with x/y.
    always_ff @(posedge i_wire_5x_pixel_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            de          <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            frame_start <= 1'b0;
        end else begin
            de          <= de_next;
            hsync       <= (on_next && h_sync) ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= (on_next && v_sync) ? VSYNC_POL : ~VSYNC_POL;
            frame_start <= start || (v_wrap && i_wire_enable);
        end
    end

    // Fetch handshake; a fresh request keeps req high and retargets line_num.
    always_ff @(posedge i_wire_5x_pixel_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            req       <= 1'b0;
            line_num  <= '0;
            underflow <= 1'b0;
        end else begin
            if (new_req) begin
                req      <= 1'b1;
                line_num <= start ? '0 : next_line;
            end else if (i_wire_line_ack) begin
                req <= 1'b0;
            end
            if (uf_set)            underflow <= 1'b1;
            else if (i_wire_clear) underflow <= 1'b0;
        end
    end

    assign o_wire_hsync       = hsync;
    assign o_wire_vsync       = vsync;
    assign o_wire_de          = de;
    assign o_wire_x           = h;
    assign o_wire_y           = v;
    assign o_wire_frame_start = frame_start;
    assign o_wire_line_req    = req;
    assign o_wire_line_num    = line_num;
    assign o_wire_underflow   = underflow;
    assign o_wire_busy        = busy;

endmodule

// File: tb/tb_painterengine_gpu_video_scheduler.sv
// Bench for the video scheduler on a small 14x7 timing with
// a pixel pulse every 5 clocks.
module tb_painterengine_gpu_video_scheduler;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic pix = 1'b0;
    logic en = 1'b0;
    logic ack = 1'b0;
    logic clr = 1'b0;

    logic        hsync, vsync, de, fs, req, uf, busy;
    logic [11:0] x, y, num;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic        fs;
        logic        req;
        logic [11:0] num;
        logic        uf;
        logic        busy;
    } obs_t;

    typedef struct {
        int   k;
        obs_t exp;
    } vec_t;

    int checks = 0;
    int fails = 0;
    int k = -1;
    bit pix_run = 1'b0;
    bit ack_en = 1'b1;
    bit stat_on = 1'b0;
    int pcnt = 0;
    int age = 0;
    int de_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_cnt = 0;
    logic req_q = 1'b0;
    logic [11:0] lq[$];
    vec_t tbl[20];

    painterengine_gpu_video_scheduler #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(12)
    ) dut (
        .i_wire_5x_pixel_clock(clk),
        .i_wire_resetn        (resetn),
        .i_wire_pixel_clock   (pix),
        .i_wire_enable        (en),
        .i_wire_line_ack      (ack),
        .i_wire_clear         (clr),
        .o_wire_hsync         (hsync),
        .o_wire_vsync         (vsync),
        .o_wire_de            (de),
        .o_wire_x             (x),
        .o_wire_y             (y),
        .o_wire_frame_start   (fs),
        .o_wire_line_req      (req),
        .o_wire_line_num      (num),
        .o_wire_underflow     (uf),
        .o_wire_busy          (busy)
    );

    always #5 clk = ~clk;

    // Pixel pulse: one clock high every 5 clocks.
    always @(negedge clk) begin
        if (!pix_run) begin
            pix = 1'b0;
        end else begin
            pix = (pcnt == 0);
            pcnt = (pcnt == 4) ? 0 : pcnt + 1;
        end
    end

    // Fetch unit stand-in: acks a request about 2 clocks after it rises.
    always @(negedge clk) begin
        ack = 1'b0;
        if (req === 1'b1) begin
            if (ack_en && age >= 1) ack = 1'b1;
            age++;
        end else begin
            age = 0;
        end
    end

    // Record line_num at each rising request.
    always @(posedge clk) begin
        #1;
        if (req === 1'b1 && req_q === 1'b0) lq.push_back(num);
        req_q = req;
    end

    function automatic obs_t mk(int ox, int oy, bit ode, bit hs_act,
                                bit vs_act, bit ofs, bit oreq, int onum,
                                bit ouf, bit obusy);
        obs_t o;
        o.hs = !hs_act;
        o.vs = !vs_act;
        o.de = ode;
        o.x = 12'(ox);
        o.y = 12'(oy);
        o.fs = ofs;
        o.req = oreq;
        o.num = 12'(onum);
        o.uf = ouf;
        o.busy = obusy;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("x=%0d y=%0d de=%b hs=%b vs=%b fs=%b req=%b num=%0d uf=%b busy=%b",
                         o.x, o.y, o.de, o.hs, o.vs, o.fs, o.req, o.num, o.uf, o.busy);
    endfunction

    task automatic check(string name, obs_t exp);
        obs_t a;
        a = '{hs: hsync, vs: vsync, de: de, x: x, y: y, fs: fs, req: req,
              num: num, uf: uf, busy: busy};
        checks++;
        if (a !== exp) begin
            fails++;
            $display("FAIL %s: got {%s} expected {%s}", name, fmt(a), fmt(exp));
        end
    endtask

    task automatic chk_int(string name, int got, int want);
        checks++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Advance to just after the next clock edge that carries a pixel pulse.
    task automatic step_one();
        int n;
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 20) begin
            @(posedge clk);
            n++;
            hit = (pix == 1'b1);
        end
        #1;
        k++;
        if (!hit) begin
            fails++;
            checks++;
            $display("FAIL pulse_timeout: got no pulse in %0d clocks expected one", n);
        end
        if (stat_on && k >= 1) begin
            de_cnt += int'(de);
            hs_cnt += int'(!hsync);
            vs_cnt += int'(!vsync);
            fs_cnt += int'(fs);
        end
    endtask

    task automatic goto_k(int target);
        while (k < target) step_one();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t rst_o;
        logic [19:0] seq;
        rst_o = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        tbl[0]  = '{0,  mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 1)};
        tbl[1]  = '{1,  mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1)};
        tbl[2]  = '{7,  mk(7, 0, 1, 0, 0, 0, 0, 0, 0, 1)};
        tbl[3]  = '{8,  mk(8, 0, 0, 0, 0, 0, 1, 1, 0, 1)};
        tbl[4]  = '{10, mk(10, 0, 0, 1, 0, 0, 0, 1, 0, 1)};
        tbl[5]  = '{11, mk(11, 0, 0, 1, 0, 0, 0, 1, 0, 1)};
        tbl[6]  = '{12, mk(12, 0, 0, 0, 0, 0, 0, 1, 0, 1)};
        tbl[7]  = '{13, mk(13, 0, 0, 0, 0, 0, 0, 1, 0, 1)};
        tbl[8]  = '{14, mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 1)};
        tbl[9]  = '{22, mk(8, 1, 0, 0, 0, 0, 1, 2, 0, 1)};
        tbl[10] = '{36, mk(8, 2, 0, 0, 0, 0, 1, 3, 0, 1)};
        tbl[11] = '{50, mk(8, 3, 0, 0, 0, 0, 0, 3, 0, 1)};
        tbl[12] = '{56, mk(0, 4, 0, 0, 0, 0, 0, 3, 0, 1)};
        tbl[13] = '{70, mk(0, 5, 0, 0, 1, 0, 0, 3, 0, 1)};
        tbl[14] = '{80, mk(10, 5, 0, 1, 1, 0, 0, 3, 0, 1)};
        tbl[15] = '{83, mk(13, 5, 0, 0, 1, 0, 0, 3, 0, 1)};
        tbl[16] = '{84, mk(0, 6, 0, 0, 0, 0, 0, 3, 0, 1)};
        tbl[17] = '{92, mk(8, 6, 0, 0, 0, 0, 1, 0, 0, 1)};
        tbl[18] = '{97, mk(13, 6, 0, 0, 0, 0, 0, 0, 0, 1)};
        tbl[19] = '{98, mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 1)};

        pix_run = 1'b1;
        repeat (3) @(negedge clk);
        check("reset", rst_o);
        resetn = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("idle_no_enable", rst_o);

        // First frame, free running with prompt acks.
        lq.delete();
        stat_on = 1'b1;
        k = -1;
        en = 1'b1;
        foreach (tbl[i]) begin
            goto_k(tbl[i].k);
            check($sformatf("frame1_k%0d", tbl[i].k), tbl[i].exp);
        end
        stat_on = 1'b0;
        chk_int("de_pixels", de_cnt, 32);
        chk_int("hsync_pixels", hs_cnt, 14);
        chk_int("vsync_pixels", vs_cnt, 14);
        chk_int("frame_starts", fs_cnt, 1);
        seq = '1;
        if (lq.size() == 5)
            seq = {lq[0][3:0], lq[1][3:0], lq[2][3:0], lq[3][3:0], lq[4][3:0]};
        chk_int("line_seq", int'(seq), 32'h01230);

        // Withheld ack: underflow at the next de rise, line_num retargets.
        ack_en = 1'b0;
        goto_k(106);
        check("uf_pending", mk(8, 0, 0, 0, 0, 0, 1, 1, 0, 1));
        goto_k(112);
        check("uf_de_rise", mk(0, 1, 1, 0, 0, 0, 1, 1, 1, 1));
        goto_k(120);
        check("uf_retarget", mk(8, 1, 0, 0, 0, 0, 1, 2, 1, 1));
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        check("uf_clear", mk(8, 1, 0, 0, 0, 0, 1, 2, 0, 1));
        @(negedge clk);
        clr = 1'b0;
        ack_en = 1'b1;
        goto_k(126);
        check("uf_recovered", mk(0, 2, 1, 0, 0, 0, 0, 2, 0, 1));
        goto_k(134);
        check("req_line3", mk(8, 2, 0, 0, 0, 0, 1, 3, 0, 1));

        // Drain: frame completes, no requests, idles on v wrap.
        en = 1'b0;
        goto_k(190);
        check("drain_no_req", mk(8, 6, 0, 0, 0, 0, 0, 3, 0, 1));
        goto_k(196);
        check("drain_idle", mk(0, 0, 0, 0, 0, 0, 0, 3, 0, 0));
        goto_k(201);
        check("idle_hold", mk(0, 0, 0, 0, 0, 0, 0, 3, 0, 0));

        // Restart, then re-enable mid-drain.
        k = -1;
        en = 1'b1;
        goto_k(0);
        check("restart", mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 1));
        goto_k(30);
        check("pre_drain", mk(2, 2, 1, 0, 0, 0, 0, 2, 0, 1));
        en = 1'b0;
        goto_k(60);
        check("drain_busy", mk(4, 4, 0, 0, 0, 0, 0, 2, 0, 1));
        en = 1'b1;
        goto_k(92);
        check("reenable_req", mk(8, 6, 0, 0, 0, 0, 1, 0, 0, 1));
        goto_k(98);
        check("reenable_frame", mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 1));

        // Asynchronous reset mid-frame.
        goto_k(117);
        check("pre_reset", mk(5, 1, 1, 0, 0, 0, 0, 1, 0, 1));
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset", rst_o);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
